// File: rtl/result_drain_collector.sv
// Deskews the per-column result stream from the mesh south edge into aligned rows.
// Optional row index output is enabled by defining RESULT_DRAIN_ROW_TAG_EN.
module result_drain_collector #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [N*DATA_WIDTH-1:0] south_i,
    input  logic [N-1:0]            south_valid_i,
    output logic [N*DATA_WIDTH-1:0] row_data_o,
    output logic                    row_valid_o,
    input  logic                    row_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    overflow_o
`ifdef RESULT_DRAIN_ROW_TAG_EN
    ,
    output logic [$clog2(N)-1:0]    row_idx_o
`endif
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ROW_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                    collecting;
    logic                    clear;
    logic                    transfer;
    logic                    pop;
    logic                    last_xfer;
    logic [N-1:0]            push;
    logic [N-1:0]            accept;
    logic [N-1:0]            nonempty;
    logic [N*DATA_WIDTH-1:0] heads;
    logic [ROW_W-1:0]        row_cnt_q;
    logic [ROW_W-1:0]        xfer_cnt_q;
    logic [N*DATA_WIDTH-1:0] row_data_q;
    logic                    row_valid_q;
    logic                    overflow_q;

    assign collecting = (state_q == COLLECT);
    assign clear      = start_i && !collecting;
    assign transfer   = row_valid_q && row_ready_i;
    // Only N rows are ever loaded per matrix; anything left in the FIFOs stays put.
    assign pop        = collecting && (&nonempty) && (!row_valid_q || transfer)
                        && (row_cnt_q < ROW_W'(N));
    assign last_xfer  = collecting && transfer && (xfer_cnt_q == ROW_W'(N - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = COLLECT;
            COLLECT: if (last_xfer) state_d = DONE;
            DONE:    if (start_i)   state_d = COLLECT;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            COLLECT: busy_o = 1'b1;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_col
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [CNT_W-1:0]      count_q;
        logic                  full;

        assign full         = (count_q == CNT_W'(DEPTH));
        assign nonempty[gi] = (count_q != '0);
        assign push[gi]     = collecting && south_valid_i[gi];
        // A full FIFO still takes a push when its head leaves on the same edge.
        assign accept[gi]   = push[gi] && (!full || pop);
        assign heads[gi*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];

        always_ff @(posedge clk_i) begin
            if (accept[gi]) begin
                mem_q[wr_ptr_q] <= south_i[gi*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (accept[gi]) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
                end
                if (accept[gi] && !pop) begin
                    count_q <= count_q + CNT_W'(1);
                end else if (!accept[gi] && pop) begin
                    count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            row_cnt_q   <= '0;
            xfer_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else if (clear) begin
            row_data_q  <= '0;
            row_valid_q <= 1'b0;
            row_cnt_q   <= '0;
            xfer_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (pop) begin
                row_data_q  <= heads;
                row_valid_q <= 1'b1;
                row_cnt_q   <= row_cnt_q + ROW_W'(1);
            end else if (transfer) begin
                row_valid_q <= 1'b0;
            end
            if (collecting && transfer) begin
                xfer_cnt_q <= xfer_cnt_q + ROW_W'(1);
            end
            if (|(push & ~accept)) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef RESULT_DRAIN_ROW_TAG_EN
    logic [$clog2(N)-1:0] row_idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_idx_q <= '0;
        end else if (clear) begin
            row_idx_q <= '0;
        end else if (pop) begin
            row_idx_q <= row_cnt_q[$clog2(N)-1:0];
        end
    end

    assign row_idx_o = row_idx_q;
`endif

    assign row_data_o  = row_data_q;
    assign row_valid_o = row_valid_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_result_drain_collector.sv
// Bench for result_drain_collector (N=4, DEPTH=4, DW=32): vector table, corner sequences,
// and randomized matrices checked against a row-by-row scoreboard.
module tb_result_drain_collector;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int RW    = N * DW;
    localparam int NCYC  = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [RW-1:0] south;
    logic [N-1:0]  svalid;
    logic [RW-1:0] row_data;
    logic          row_valid;
    logic          ready;
    logic          busy;
    logic          done;
    logic          overflow;
`ifdef RESULT_DRAIN_ROW_TAG_EN
    logic [$clog2(N)-1:0] row_idx;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0]  svalid;
        logic [RW-1:0] sdata;
        logic          ready;
        logic          exp_valid;
        logic [RW-1:0] exp_data;
        int            exp_idx;
        logic          exp_busy;
        logic          exp_done;
    } vec_t;

    vec_t tbl [NCYC];

    result_drain_collector #(
        .N          (N),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .south_i       (south),
        .south_valid_i (svalid),
        .row_data_o    (row_data),
        .row_valid_o   (row_valid),
        .row_ready_i   (ready),
        .busy_o        (busy),
        .done_o        (done),
        .overflow_o    (overflow)
`ifdef RESULT_DRAIN_ROW_TAG_EN
        ,
        .row_idx_o     (row_idx)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mk_row(input int base, input int r);
        logic [RW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(base + 10 * r + j);
        return v;
    endfunction

    // Skewed wavefront: column j carries element r during cycle r+j.
    task automatic set_skew(input int c);
        for (int j = 0; j < N; j++) begin
            if (c - j >= 0 && c - j < N) begin
                svalid[j] = 1'b1;
                south[j*DW +: DW] = DW'(10 * (c - j) + j);
            end else begin
                svalid[j] = 1'b0;
                south[j*DW +: DW] = '0;
            end
        end
    endtask

    function automatic void build_table();
        for (int c = 0; c < NCYC; c++) begin
            tbl[c].svalid = '0;
            tbl[c].sdata  = '0;
            for (int j = 0; j < N; j++) begin
                if (c - j >= 0 && c - j < N) begin
                    tbl[c].svalid[j] = 1'b1;
                    tbl[c].sdata[j*DW +: DW] = DW'(10 * (c - j) + j);
                end
            end
            tbl[c].ready     = 1'b1;
            tbl[c].exp_valid = (c >= 5 && c <= 8);
            tbl[c].exp_data  = tbl[c].exp_valid ? mk_row(0, c - 5) : '0;
            tbl[c].exp_idx   = c - 5;
            tbl[c].exp_busy  = (c < 9);
            tbl[c].exp_done  = (c == 9);
        end
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic run_skew_table(input bit with_start);
        if (with_start) do_start();
        for (int c = 0; c < NCYC; c++) begin
            check("skew_valid", row_valid, tbl[c].exp_valid);
            if (tbl[c].exp_valid) begin
                check("skew_data", row_data, tbl[c].exp_data);
`ifdef RESULT_DRAIN_ROW_TAG_EN
                check("skew_row_idx", row_idx, tbl[c].exp_idx);
`endif
            end
            check("skew_busy", busy, tbl[c].exp_busy);
            check("skew_done", done, tbl[c].exp_done);
            svalid = tbl[c].svalid;
            south  = tbl[c].sdata;
            ready  = tbl[c].ready;
            @(negedge clk);
        end
        svalid = '0;
        south  = '0;
        check("skew_overflow", overflow, 1'b0);
    endtask

    task automatic run_random(input int it);
        logic [DW-1:0] mat [N][N];
        int            sent [N];
        int            cyc;
        int            ready_pct;
        bit            stalled;
        logic [RW-1:0] held;
        logic [RW-1:0] exp_row;
        logic [RW-1:0] got [$];
        int            got_idx [$];
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++) mat[r][j] = $urandom;
        for (int j = 0; j < N; j++) sent[j] = 0;
        stalled   = 1'b0;
        held      = '0;
        cyc       = 0;
        ready_pct = $urandom_range(30, 100);
        do_start();
        while (!done && cyc < 300) begin
            if (stalled) begin
                check("rand_hold_valid", row_valid, 1'b1);
                check("rand_hold_data", row_data, held);
            end
            ready = ($urandom_range(1, 100) <= ready_pct);
            for (int j = 0; j < N; j++) begin
                if (sent[j] < N && $urandom_range(0, 1) == 1) begin
                    svalid[j] = 1'b1;
                    south[j*DW +: DW] = mat[sent[j]][j];
                    sent[j]++;
                end else begin
                    svalid[j] = 1'b0;
                    south[j*DW +: DW] = '0;
                end
            end
            if (row_valid && ready) begin
                got.push_back(row_data);
`ifdef RESULT_DRAIN_ROW_TAG_EN
                got_idx.push_back(int'(row_idx));
`endif
            end
            stalled = row_valid && !ready;
            held    = row_data;
            @(negedge clk);
            cyc++;
        end
        svalid = '0;
        south  = '0;
        ready  = 1'b0;
        check("rand_done", done, 1'b1);
        check("rand_busy", busy, 1'b0);
        check("rand_row_count", got.size(), N);
        check("rand_overflow", overflow, 1'b0);
        for (int r = 0; r < got.size() && r < N; r++) begin
            exp_row = '0;
            for (int j = 0; j < N; j++) exp_row[j*DW +: DW] = mat[r][j];
            check("rand_row", got[r], exp_row);
`ifdef RESULT_DRAIN_ROW_TAG_EN
            check("rand_row_idx", got_idx[r], r);
`endif
        end
        $display("matrix %0d: %0d rows collected in %0d cycles", it, got.size(), cyc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        ready  = 1'b0;
        svalid = '0;
        south  = '0;
        build_table();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", row_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_data", row_data, '0);
        rst = 1'b0;
        @(negedge clk);

        // Basic skewed matrix with ready held high
        run_skew_table(1'b1);

        // Backpressure: row 0 held for six cycles, then rows drain back-to-back
        do_start();
        for (int c = 0; c < 16; c++) begin
            if (c >= 5 && c <= 11) begin
                check("bp_hold_valid", row_valid, 1'b1);
                check("bp_hold_data", row_data, mk_row(0, 0));
            end
            if (c >= 12 && c <= 14) begin
                check("bp_valid", row_valid, 1'b1);
                check("bp_data", row_data, mk_row(0, c - 11));
            end
            if (c == 15) check("bp_done", done, 1'b1);
            set_skew(c);
            ready = (c >= 11);
            @(negedge clk);
        end
        check("bp_overflow", overflow, 1'b0);

        // Overflow: column 0 alone pushes five values into a 4-deep FIFO
        do_start();
        ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 4) check("ovf_before", overflow, 1'b0);
            if (c == 5) begin
                check("ovf_after", overflow, 1'b1);
                check("ovf_no_row", row_valid, 1'b0);
            end
            svalid = (c < 5) ? 4'b0001 : 4'b0000;
            south  = '0;
            south[DW-1:0] = DW'(100 + c);
            @(negedge clk);
        end
        for (int c = 0; c < N; c++) begin
            svalid = 4'b1110;
            south  = mk_row(100, c);
            @(negedge clk);
        end
        svalid = '0;
        wait_done("ovf_done", 40);
        check("ovf_sticky", overflow, 1'b1);
        do_start();
        check("ovf_cleared", overflow, 1'b0);
        check("ovf_restart_done", done, 1'b0);
        check("ovf_restart_busy", busy, 1'b1);
        run_skew_table(1'b0);

        // Full FIFOs with a transfer on the same edge as a push to column 2
        do_start();
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            svalid = 4'b1111;
            south  = mk_row(200, c);
            @(negedge clk);
        end
        check("full_valid", row_valid, 1'b1);
        check("full_data", row_data, mk_row(200, 0));
        check("full_overflow_pre", overflow, 1'b0);
        ready  = 1'b1;
        svalid = 4'b0100;
        south  = '0;
        south[2*DW +: DW] = 32'd99;
        @(negedge clk);
        svalid = '0;
        south  = '0;
        check("full_overflow_post", overflow, 1'b0);
        for (int c = 1; c < N; c++) begin
            check("full_row_valid", row_valid, 1'b1);
            check("full_row_data", row_data, mk_row(200, c));
            @(negedge clk);
        end
        check("full_done", done, 1'b1);
        check("full_overflow_end", overflow, 1'b0);

        // Asynchronous reset after two rows have transferred
        do_start();
        for (int c = 0; c < 7; c++) begin
            set_skew(c);
            ready = 1'b1;
            @(negedge clk);
        end
        check("rstmid_pre_valid", row_valid, 1'b1);
        check("rstmid_pre_data", row_data, mk_row(0, 2));
        rst = 1'b1;
        #1;
        check("rstmid_valid", row_valid, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_overflow", overflow, 1'b0);
        check("rstmid_data", row_data, '0);
`ifdef RESULT_DRAIN_ROW_TAG_EN
        check("rstmid_row_idx", row_idx, '0);
`endif
        @(negedge clk);
        rst    = 1'b0;
        svalid = '0;
        south  = '0;
        @(negedge clk);
        run_skew_table(1'b1);

        for (int it = 0; it < 20; it++) run_random(it);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
